// File: rtl/mem_pkg.sv
// Shared types and helpers for the main-memory controller: FSM states,
// request sources, line geometry and store lane encoding.
package mem_pkg;

    localparam int ADDR_W     = 20;
    localparam int LINE_BITS  = 128;
    localparam int OFFSET_W   = 4;
    localparam int LINE_BYTES = LINE_BITS / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SRC_IC = 2'd0,
        SRC_DC = 2'd1,
        SRC_WR = 2'd2
    } src_e;

    // Byte stores touch one lane chosen by the full offset; word stores ignore offset[1:0].
    function automatic logic [LINE_BYTES-1:0] store_be(
        input logic [OFFSET_W-1:0] offset,
        input logic                is_byte
    );
        logic [LINE_BYTES-1:0] be;
        be = '0;
        if (is_byte) begin
            be[offset] = 1'b1;
        end else begin
            be[{offset[3:2], 2'b00} +: 4] = 4'hF;
        end
        return be;
    endfunction

    function automatic logic [LINE_BITS-1:0] store_data(
        input logic [31:0] data,
        input logic        is_byte
    );
        return is_byte ? {LINE_BYTES{data[7:0]}} : {(LINE_BITS / 32){data}};
    endfunction

endpackage

// File: rtl/mem_backing_store.sv
// Synchronous line-wide backing array with a registered read port and a
// byte-enabled write port. Contents are deliberately not reset.
module mem_backing_store
    import mem_pkg::*;
#(
    parameter int IDX_W = 12
) (
    input  logic                  clk_i,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [LINE_BITS-1:0]  rd_line,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [LINE_BYTES-1:0] wr_be,
    input  logic [LINE_BITS-1:0]  wr_data
);

    logic [LINE_BITS-1:0] mem [1 << IDX_W];

    always_ff @(posedge clk_i) begin
        rd_line <= mem[rd_idx];
        if (wr_en) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Single-port main-memory controller serving icache/dcache line fills and
// dcache write-through stores with a fixed access latency.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_LATENCY = 5,
    parameter int MEM_IDX_W   = 12
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 ic_rqst_i,
    input  logic [ADDR_W-1:0]    ic_addr_i,
    input  logic                 ic_kill_i,
    input  logic                 dc_rqst_i,
    input  logic [ADDR_W-1:0]    dc_addr_i,
    input  logic                 dc_kill_i,
    input  logic                 dc_wr_i,
    input  logic [ADDR_W-1:0]    dc_wr_addr_i,
    input  logic [31:0]          dc_wr_data_i,
    input  logic                 dc_wr_byte_i,
    output logic                 ic_data_ready_o,
    output logic                 dc_data_ready_o,
    output logic                 dc_wr_ack_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_line_o,
    output logic                 busy_o
);

    localparam int                CNT_W    = $clog2(MEM_LATENCY);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    src_e                 src_q, src_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 wbyte_q, wbyte_d;
    logic                 squash_q, squash_d;

    logic                 ic_pend_vld_q, dc_pend_vld_q;
    logic [ADDR_W-1:0]    ic_pend_addr_q, dc_pend_addr_q;

    logic                 wr_want, dc_want, ic_want;
    logic [ADDR_W-1:0]    dc_req_addr, ic_req_addr;
    logic                 grant_ic, grant_dc;
    logic                 done_rd, done_wr;
    logic                 kill_hit, squash_now;
    logic [LINE_BITS-1:0] rd_line;

    // A request pulse arriving while IDLE is granted in the same cycle; otherwise the
    // pending register holds it. The ack cycle never re-grants the store it just acked.
    assign wr_want     = dc_wr_i & ~dc_wr_ack_o;
    assign dc_want     = dc_rqst_i | (dc_pend_vld_q & ~dc_kill_i);
    assign ic_want     = ic_rqst_i | (ic_pend_vld_q & ~ic_kill_i);
    assign dc_req_addr = dc_rqst_i ? dc_addr_i : dc_pend_addr_q;
    assign ic_req_addr = ic_rqst_i ? ic_addr_i : ic_pend_addr_q;

    assign kill_hit   = (state_q == READ) &&
                        (((src_q == SRC_IC) && ic_kill_i) || ((src_q == SRC_DC) && dc_kill_i));
    assign squash_now = squash_q | kill_hit;
    assign busy_o     = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        src_d    = src_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wbyte_d  = wbyte_q;
        squash_d = squash_q;
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        done_rd  = 1'b0;
        done_wr  = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_want) begin
                    src_d    = SRC_WR;
                    addr_d   = dc_wr_addr_i;
                    wdata_d  = dc_wr_data_i;
                    wbyte_d  = dc_wr_byte_i;
                    squash_d = 1'b0;
                    cnt_d    = CNT_LOAD;
                    state_d  = WRITE;
                end else if (dc_want) begin
                    grant_dc = 1'b1;
                    src_d    = SRC_DC;
                    addr_d   = dc_req_addr;
                    squash_d = 1'b0;
                    cnt_d    = CNT_LOAD;
                    state_d  = READ;
                end else if (ic_want) begin
                    grant_ic = 1'b1;
                    src_d    = SRC_IC;
                    addr_d   = ic_req_addr;
                    squash_d = 1'b0;
                    cnt_d    = CNT_LOAD;
                    state_d  = READ;
                end
            end
            READ: begin
                if (kill_hit) begin
                    squash_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    done_rd  = 1'b1;
                    squash_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WRITE: begin
                if (cnt_q == '0) begin
                    done_wr = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            src_q    <= SRC_IC;
            addr_q   <= '0;
            wdata_q  <= '0;
            wbyte_q  <= 1'b0;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            src_q    <= src_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wbyte_q  <= wbyte_d;
            squash_q <= squash_d;
        end
    end

    // Grant consumes the pending entry; a fresh pulse otherwise overwrites it, and kill drops it.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            ic_pend_vld_q  <= 1'b0;
            ic_pend_addr_q <= '0;
            dc_pend_vld_q  <= 1'b0;
            dc_pend_addr_q <= '0;
        end else begin
            if (grant_ic) begin
                ic_pend_vld_q <= 1'b0;
            end else if (ic_rqst_i) begin
                ic_pend_vld_q  <= 1'b1;
                ic_pend_addr_q <= ic_addr_i;
            end else if (ic_kill_i) begin
                ic_pend_vld_q <= 1'b0;
            end

            if (grant_dc) begin
                dc_pend_vld_q <= 1'b0;
            end else if (dc_rqst_i) begin
                dc_pend_vld_q  <= 1'b1;
                dc_pend_addr_q <= dc_addr_i;
            end else if (dc_kill_i) begin
                dc_pend_vld_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            ic_data_ready_o <= 1'b0;
            dc_data_ready_o <= 1'b0;
            dc_wr_ack_o     <= 1'b0;
            mem_addr_o      <= '0;
            mem_line_o      <= '0;
        end else begin
            ic_data_ready_o <= done_rd && (src_q == SRC_IC) && !squash_now;
            dc_data_ready_o <= done_rd && (src_q == SRC_DC) && !squash_now;
            dc_wr_ack_o     <= done_wr;
            if (done_rd) begin
                mem_addr_o <= addr_q;
                mem_line_o <= rd_line;
            end
        end
    end

    mem_backing_store #(
        .IDX_W (MEM_IDX_W)
    ) u_store (
        .clk_i   (clk_i),
        .rd_idx  (addr_q[OFFSET_W +: MEM_IDX_W]),
        .rd_line (rd_line),
        .wr_en   (done_wr),
        .wr_idx  (addr_q[OFFSET_W +: MEM_IDX_W]),
        .wr_be   (store_be(addr_q[OFFSET_W-1:0], wbyte_q)),
        .wr_data (store_data(wdata_q, wbyte_q))
    );

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected pulses (cycle, address,
// line) from a line-level memory model; a negedge monitor pops and compares.
module tb_mem_ctrl;
    import mem_pkg::*;

    localparam int LAT = 5;

    logic         clk_i = 1'b0;
    logic         rsn_i = 1'b0;
    logic         ic_rqst_i = 1'b0, ic_kill_i = 1'b0;
    logic         dc_rqst_i = 1'b0, dc_kill_i = 1'b0;
    logic [19:0]  ic_addr_i = '0, dc_addr_i = '0;
    logic         dc_wr_i = 1'b0, dc_wr_byte_i = 1'b0;
    logic [19:0]  dc_wr_addr_i = '0;
    logic [31:0]  dc_wr_data_i = '0;
    logic         ic_data_ready_o, dc_data_ready_o, dc_wr_ack_o, busy_o;
    logic [19:0]  mem_addr_o;
    logic [127:0] mem_line_o;

    mem_ctrl #(
        .MEM_LATENCY (LAT),
        .MEM_IDX_W   (12)
    ) dut (
        .clk_i           (clk_i),
        .rsn_i           (rsn_i),
        .ic_rqst_i       (ic_rqst_i),
        .ic_addr_i       (ic_addr_i),
        .ic_kill_i       (ic_kill_i),
        .dc_rqst_i       (dc_rqst_i),
        .dc_addr_i       (dc_addr_i),
        .dc_kill_i       (dc_kill_i),
        .dc_wr_i         (dc_wr_i),
        .dc_wr_addr_i    (dc_wr_addr_i),
        .dc_wr_data_i    (dc_wr_data_i),
        .dc_wr_byte_i    (dc_wr_byte_i),
        .ic_data_ready_o (ic_data_ready_o),
        .dc_data_ready_o (dc_data_ready_o),
        .dc_wr_ack_o     (dc_wr_ack_o),
        .mem_addr_o      (mem_addr_o),
        .mem_line_o      (mem_line_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [19:0]  addr;
        logic [127:0] line;
        int           cyc;
    } fill_t;

    fill_t        ic_q[$];
    fill_t        dc_q[$];
    int           ack_q[$];
    fill_t        mon_ic, mon_dc;
    int           mon_ack;
    logic [127:0] model_line [int];
    int           line_set [8] = '{32'h010, 32'h234, 32'h001, 32'h7FF, 32'hFFF, 32'h000, 32'h555, 32'hAAA};

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int line_idx(input logic [19:0] a);
        return int'(a[15:4]);
    endfunction

    function automatic logic [19:0] rand_addr();
        logic [19:0] a;
        a[19:16] = 4'($urandom);
        a[15:4]  = 12'(line_set[$urandom_range(0, 7)]);
        a[3:0]   = 4'($urandom);
        return a;
    endfunction

    // Monitor: every pulse must match the oldest expectation on its channel, on time.
    always @(negedge clk_i) begin
        if (dc_data_ready_o) begin
            if (dc_q.size() == 0) begin
                checkOutput("dc_spurious_pulse", 128'(dc_data_ready_o), 128'(0));
            end else begin
                mon_dc = dc_q.pop_front();
                checkOutput("dc_ready_cycle", 128'(cyc), 128'(mon_dc.cyc));
                checkOutput("dc_mem_addr", 128'(mem_addr_o), 128'(mon_dc.addr));
                checkOutput("dc_mem_line", mem_line_o, mon_dc.line);
            end
        end else if (dc_q.size() > 0 && dc_q[0].cyc <= cyc) begin
            checkOutput("dc_ready_missing", 128'(dc_data_ready_o), 128'(1));
            void'(dc_q.pop_front());
        end

        if (ic_data_ready_o) begin
            if (ic_q.size() == 0) begin
                checkOutput("ic_spurious_pulse", 128'(ic_data_ready_o), 128'(0));
            end else begin
                mon_ic = ic_q.pop_front();
                checkOutput("ic_ready_cycle", 128'(cyc), 128'(mon_ic.cyc));
                checkOutput("ic_mem_addr", 128'(mem_addr_o), 128'(mon_ic.addr));
                checkOutput("ic_mem_line", mem_line_o, mon_ic.line);
            end
        end else if (ic_q.size() > 0 && ic_q[0].cyc <= cyc) begin
            checkOutput("ic_ready_missing", 128'(ic_data_ready_o), 128'(1));
            void'(ic_q.pop_front());
        end

        if (dc_wr_ack_o) begin
            if (ack_q.size() == 0) begin
                checkOutput("ack_spurious_pulse", 128'(dc_wr_ack_o), 128'(0));
            end else begin
                mon_ack = ack_q.pop_front();
                checkOutput("ack_cycle", 128'(cyc), 128'(mon_ack));
            end
        end else if (ack_q.size() > 0 && ack_q[0] <= cyc) begin
            checkOutput("ack_missing", 128'(dc_wr_ack_o), 128'(1));
            void'(ack_q.pop_front());
        end
    end

    // Issues fill pulses with the DUT idle; dc wins, so a same-cycle ic fill lands one slot later.
    task automatic applyStimulus(input logic ic_en, input logic [19:0] ic_a,
                                 input logic dc_en, input logic [19:0] dc_a);
        int e0;
        @(posedge clk_i); #1;
        ic_rqst_i = ic_en; ic_addr_i = ic_a;
        dc_rqst_i = dc_en; dc_addr_i = dc_a;
        e0 = cyc + 1;
        if (dc_en) dc_q.push_back('{dc_a, model_line[line_idx(dc_a)], e0 + LAT});
        if (ic_en) ic_q.push_back('{ic_a, model_line[line_idx(ic_a)], e0 + LAT + (dc_en ? LAT + 1 : 0)});
        @(posedge clk_i); #1;
        ic_rqst_i = 1'b0;
        dc_rqst_i = 1'b0;
    endtask

    task automatic do_store(input logic [19:0] a, input logic [31:0] d, input logic is_byte);
        logic [127:0] tmp;
        bit           got;
        @(posedge clk_i); #1;
        dc_wr_i = 1'b1; dc_wr_addr_i = a; dc_wr_data_i = d; dc_wr_byte_i = is_byte;
        ack_q.push_back(cyc + 1 + LAT);
        if (!model_line.exists(line_idx(a))) model_line[line_idx(a)] = 'x;
        tmp = model_line[line_idx(a)];
        if (is_byte) tmp[8*int'(a[3:0]) +: 8] = d[7:0];
        else         tmp[32*int'(a[3:2]) +: 32] = d;
        model_line[line_idx(a)] = tmp;
        got = 0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk_i);
            if (dc_wr_ack_o) got = 1;
        end
        dc_wr_i = 1'b0;
        if (!got) checkOutput("store_ack_timeout", 128'(dc_wr_ack_o), 128'(1));
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && (ic_q.size() + dc_q.size() + ack_q.size()) > 0; n++) @(negedge clk_i);
        if ((ic_q.size() + dc_q.size() + ack_q.size()) > 0) begin
            checkOutput("drain_timeout", 128'(ic_q.size() + dc_q.size() + ack_q.size()), 128'(0));
            ic_q.delete(); dc_q.delete(); ack_q.delete();
        end
        @(negedge clk_i);
    endtask

    task automatic killed_fill(input bit side_dc, input logic [19:0] a, input int kill_at, input bit check_busy);
        int e0;
        if (side_dc) applyStimulus(1'b0, 20'h0, 1'b1, a);
        else         applyStimulus(1'b1, a, 1'b0, 20'h0);
        e0 = cyc;
        if (side_dc) void'(dc_q.pop_back());
        else         void'(ic_q.pop_back());
        for (int i = 0; i < LAT; i++) begin
            if (i == kill_at) begin
                if (side_dc) dc_kill_i = 1'b1; else ic_kill_i = 1'b1;
            end
            @(negedge clk_i);
            dc_kill_i = 1'b0; ic_kill_i = 1'b0;
            if (check_busy) checkOutput("busy_during_killed_fill", 128'(busy_o), 128'(1));
        end
        while (cyc < e0 + LAT + 1) @(negedge clk_i);
        if (check_busy) begin
            checkOutput("busy_after_killed_fill", 128'(busy_o), 128'(0));
            checkOutput("no_ready_after_kill", 128'(dc_data_ready_o), 128'(0));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [19:0] a, b;
        int          kind;
        bit          seen;

        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset_busy", 128'(busy_o), 128'(0));
        checkOutput("reset_ic_ready", 128'(ic_data_ready_o), 128'(0));
        checkOutput("reset_dc_ready", 128'(dc_data_ready_o), 128'(0));
        checkOutput("reset_wr_ack", 128'(dc_wr_ack_o), 128'(0));
        checkOutput("reset_mem_addr", 128'(mem_addr_o), 128'(0));
        checkOutput("reset_mem_line", mem_line_o, 128'(0));
        @(negedge clk_i);
        rsn_i = 1'b1;

        // Fully define every line the bench will ever fetch.
        foreach (line_set[j]) begin
            for (int w = 0; w < 4; w++) begin
                do_store({4'h0, 12'(line_set[j]), 2'(w), 2'b00}, $urandom, 1'b0);
            end
        end
        drain();

        $display("[TB] basic dc fill");
        applyStimulus(1'b0, 20'h0, 1'b1, 20'h12340);
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk_i);
            seen = dc_data_ready_o;
        end
        @(negedge clk_i);
        checkOutput("busy_after_fill", 128'(busy_o), 128'(0));
        drain();

        $display("[TB] word store then fill");
        do_store(20'h00108, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 20'h0, 1'b1, 20'h00100);
        drain();
        checkOutput("word_store_lane", 128'(mem_line_o[95:64]), 128'(32'hDEADBEEF));

        $display("[TB] byte store then fill");
        do_store(20'h00103, 32'h123456A5, 1'b1);
        applyStimulus(1'b1, 20'h00100, 1'b0, 20'h0);
        drain();
        checkOutput("byte_store_lane", 128'(mem_line_o[31:24]), 128'(8'hA5));

        $display("[TB] simultaneous ic and dc fills");
        applyStimulus(1'b1, 20'h07FF0, 1'b1, 20'h00010);
        drain();

        $display("[TB] killed dc fill");
        killed_fill(1'b1, 20'h55550, 1, 1'b1);
        drain();

        $display("[TB] reset during fill");
        applyStimulus(1'b0, 20'h0, 1'b1, 20'h0AAA4);
        void'(dc_q.pop_back());
        @(negedge clk_i);
        #2 rsn_i = 1'b0;
        #1;
        checkOutput("midreset_busy", 128'(busy_o), 128'(0));
        checkOutput("midreset_dc_ready", 128'(dc_data_ready_o), 128'(0));
        checkOutput("midreset_mem_addr", 128'(mem_addr_o), 128'(0));
        checkOutput("midreset_mem_line", mem_line_o, 128'(0));
        repeat (2) @(negedge clk_i);
        rsn_i = 1'b1;
        repeat (LAT + 2) @(negedge clk_i);
        applyStimulus(1'b0, 20'h0, 1'b1, 20'h0AAA4);
        drain();

        $display("[TB] randomized traffic");
        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 4);
            a = rand_addr();
            b = rand_addr();
            case (kind)
                0: do_store(a, $urandom, 1'($urandom));
                1: if ($urandom_range(0, 1) == 1) applyStimulus(1'b0, 20'h0, 1'b1, a);
                   else applyStimulus(1'b1, a, 1'b0, 20'h0);
                2: applyStimulus(1'b1, a, 1'b1, b);
                3: killed_fill(1'($urandom), a, $urandom_range(0, LAT - 1), 1'b0);
                default: begin
                    applyStimulus(1'b0, 20'h0, 1'b1, a);
                    ic_q.push_back('{b, model_line[line_idx(b)], cyc + 2 * LAT + 1});
                    ic_rqst_i = 1'b1; ic_addr_i = b;
                    @(posedge clk_i); #1;
                    ic_rqst_i = 1'b0;
                    ic_q[ic_q.size() - 1].cyc = cyc + 2 * LAT;
                end
            endcase
            drain();
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        drain();
        checkOutput("final_queues_empty", 128'(ic_q.size() + dc_q.size() + ack_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port main-memory controller that sits directly downstream of the instruction- and data-cache lookup stages. It captures line-fill requests (line address of a read miss), write-through stores from the data side, and returns 128-bit lines after a fixed latency. A one-cycle ready pulse carries the line and its address back to the requesting cache. The lookup stage matches that address on bits [19:4] to close its miss.

## Interface
- MEM_LATENCY, 5, cycles from acceptance to response (≥2)
- MEM_IDX_W, 12, log2 of lines in backing store; line index = addr[4+MEM_IDX_W-1:4]
- clk_i  in  1  clock, all state on rising edge
- rsn_i  in  1  reset, asynchronous, active-low
- ic_rqst_i  in  1  icache fill request pulse
- ic_addr_i  in  20  icache fill address
- ic_kill_i  in  1  cancel icache pending/in-flight fill
- dc_rqst_i  in  1  dcache fill request pulse
- dc_addr_i  in  20  dcache fill address
- dc_kill_i  in  1  cancel dcache pending/in-flight fill
- dc_wr_i  in  1  store request, held until dc_wr_ack_o
- dc_wr_addr_i  in  20  store byte address
- dc_wr_data_i  in  32  store data (byte in [7:0] when dc_wr_byte_i)
- dc_wr_byte_i  in  1  1 = byte store, 0 = word store (addr[1:0] ignored)
- ic_data_ready_o  out  1  icache fill done, one-cycle pulse
- dc_data_ready_o  out  1  dcache fill done, one-cycle pulse
- dc_wr_ack_o  out  1  store committed, one-cycle pulse
- mem_addr_o  out  20  address of returned line (as captured)
- mem_line_o  out  128  returned line, byte 0 in [7:0]
- busy_o  out  1  FSM not IDLE

## Operation
- Per-requester pending register (valid + addr) for ic and dc fills; rqst_i pulse sets valid and overwrites addr, even if already valid.
- kill_i clears that side's pending valid and marks its in-flight fill as squashed; kill and rqst in same cycle: new request retained, old discarded.
- FSM states: IDLE, READ, WRITE.
- IDLE arbitration, fixed priority: dc_wr_i > dc pending > ic pending. Stores first so a later fill observes them.
- Grant: latch source, address, and store data; clear the granted pending valid; load counter = MEM_LATENCY-1; go to READ or WRITE.
- READ/WRITE: counter decrements each cycle. At counter == 0:
  - READ: drive mem_line_o and mem_addr_o; pulse the source's data_ready unless squashed.
  - WRITE: update the byte or word lane selected by addr[3:0] / addr[3:2]; pulse dc_wr_ack_o.
  - Both return to IDLE.
- Squashed fill still occupies the full latency; no pulse is produced.
- mem_line_o and mem_addr_o hold their last value between pulses and are valid only while a ready pulse is high.
- Backing store contents are not reset.

## Timing
- Request or store sampled at edge E0 while IDLE. Response pulse is high in the cycle following edge E0+MEM_LATENCY.
- State is IDLE after the pulse cycle. The next grant happens at that same edge at the earliest; the minimum grant-to-grant spacing is MEM_LATENCY+1 cycles.
- A request pulse arriving while busy is held in the pending register and served at the next IDLE.
- dc_wr_i must stay high with stable address and data until the ack. The ack cycle deasserts the grant, so a held dc_wr_i after the ack counts as a new store.
- A rqst pulse in the same cycle as that side's ready pulse is captured as a new pending request.
- Reset (rsn_i low, any time) clears:
  - state to IDLE, counter to 0, pending valids and squash flags to 0;
  - all ready/ack outputs and busy_o to 0;
  - mem_addr_o and mem_line_o to 0.
  In-flight transaction is dropped with no pulse.

## Structure
- Package mem_pkg: state enum (IDLE/READ/WRITE), ADDR_W=20, LINE_BITS=128, OFFSET_W=4, source encoding (SRC_IC, SRC_DC, SRC_WR).
- Sub-module mem_backing_store: 2^MEM_IDX_W × 128-bit synchronous array. Read port: index in, line out. Write port: index, 16 byte-enables, data.

## Test plan
- Reset, then dc_rqst_i pulse with addr 0x12340 → dc_data_ready_o high exactly 5 cycles after acceptance, mem_addr_o=0x12340, busy_o low the next cycle.
- Word store 0xDEADBEEF to 0x00108, then dc fill of 0x00100 → dc_wr_ack_o first; returned line bits [95:64]=0xDEADBEEF.
- Byte store 0xA5 to 0x00103 → bits [31:24] of line 0x00100 equal 0xA5, other bytes unchanged.
- ic_rqst_i and dc_rqst_i in same cycle → dc served first, ic ready pulse 6 cycles after the dc pulse.
- dc fill in flight, dc_kill_i at cycle 2 → no dc_data_ready_o; busy_o stays high for the full latency.
- rsn_i low at cycle 3 of a fill → all outputs 0 immediately, no ready pulse; a new request after release completes normally.
